// File: rtl/avalon_rd_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_rd_arbiter
//   Two-master, one-slave Avalon-MM read arbiter. Round-robin grant, held
//   stable while the slave asserts waitrequest. An in-order tag FIFO records
//   which master issued each accepted read so readdatavalid beats are
//   returned only to their issuer.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   m0_* / m1_*         : master read ports (address, read, waitrequest,
//                         readdata, readdatavalid)
//   s_*                 : slave port (address, read, waitrequest, readdata,
//                         readdatavalid)
//   pending             : number of accepted-but-unreturned reads
//   rsp_err             : sticky flag, a response arrived with nothing pending
// ---------------------------------------------------------------------------
module avalon_rd_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_PENDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH-1:0]             m0_address,
    input  logic                              m0_read,
    output logic                              m0_waitrequest,
    output logic [DATA_WIDTH-1:0]             m0_readdata,
    output logic                              m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]             m1_address,
    input  logic                              m1_read,
    output logic                              m1_waitrequest,
    output logic [DATA_WIDTH-1:0]             m1_readdata,
    output logic                              m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic                              s_read,
    input  logic                              s_waitrequest,
    input  logic [DATA_WIDTH-1:0]             s_readdata,
    input  logic                              s_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]      pending,
    output logic                              rsp_err
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    // State
    logic                   last_grant_q, last_grant_d;
    logic                   locked_q,     locked_d;
    logic                   lock_id_q,    lock_id_d;
    logic [MAX_PENDING-1:0] tag_q,        tag_d;
    logic [PW-1:0]          wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]          count_q,      count_d;
    logic                   rsp_err_q,    rsp_err_d;

    // Combinational helpers
    logic grant_valid;
    logic grant_id;
    logic grant_read;
    logic full;
    logic accept;
    logic stall;
    logic head_id;
    logic rsp_pop;

    // Arbitration: a held lock wins; otherwise single requester wins and a
    // tie goes to the master that was not granted last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (locked_q) begin
            grant_valid = 1'b1;
            grant_id    = lock_id_q;
        end else begin
            unique case ({m1_read, m0_read})
                2'b01:   begin grant_valid = 1'b1; grant_id = 1'b0;          end
                2'b10:   begin grant_valid = 1'b1; grant_id = 1'b1;          end
                2'b11:   begin grant_valid = 1'b1; grant_id = !last_grant_q; end
                default: begin grant_valid = 1'b0; grant_id = 1'b0;          end
            endcase
        end
    end

    assign grant_read = grant_id ? m1_read : m0_read;
    assign full       = (count_q == CW'(MAX_PENDING));

    // Outputs are forced quiet while reset is held so nothing leaks out
    // before the state registers are known-clean.
    assign s_read    = !rst && grant_valid && grant_read && !full;
    assign s_address = (grant_valid && grant_id) ? m1_address : m0_address;

    assign m0_waitrequest = rst || !(grant_valid && !grant_id) || s_waitrequest || full;
    assign m1_waitrequest = rst || !(grant_valid &&  grant_id) || s_waitrequest || full;

    assign accept = s_read && !s_waitrequest;
    assign stall  = s_read &&  s_waitrequest;

    // Response routing: the FIFO head names the master owning this beat.
    assign head_id = tag_q[rd_ptr_q];
    assign rsp_pop = !rst && s_readdatavalid && (count_q != '0);

    assign m0_readdatavalid = rsp_pop && !head_id;
    assign m1_readdatavalid = rsp_pop &&  head_id;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign pending = count_q;
    assign rsp_err = rsp_err_q;

    // Next-state logic
    always_comb begin
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        lock_id_d    = lock_id_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_err_d    = rsp_err_q;

        if (accept) begin
            tag_d[wr_ptr_q] = grant_id;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            last_grant_d    = grant_id;
            locked_d        = 1'b0;
        end else if (stall) begin
            // Freeze the grant so the presented command cannot change
            // until the slave takes it.
            locked_d  = 1'b1;
            lock_id_d = grant_id;
        end

        if (rsp_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (s_readdatavalid && (count_q == '0)) begin
            rsp_err_d = 1'b1;
        end

        unique case ({accept, rsp_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            locked_q     <= 1'b0;
            lock_id_q    <= 1'b0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            lock_id_q    <= lock_id_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_avalon_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_rd_arbiter
//   Directed bench for avalon_rd_arbiter (default parameters). Inputs change
//   1 ns after each rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_avalon_rd_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m1_read, s_read;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [63:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    logic [2:0]  pending;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    avalon_rd_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .MAX_PENDING(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_address      (m0_address),
        .m0_read         (m0_read),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address      (m1_address),
        .m1_read         (m1_read),
        .m1_waitrequest  (m1_waitrequest),
        .m1_readdata     (m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .pending         (pending),
        .rsp_err         (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        if (obs === exp) $display("ok   %s value=%0h", tag, obs);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read         = 1'b0;
        m1_read         = 1'b0;
        m0_address      = '0;
        m1_address      = '0;
        s_waitrequest   = 1'b0;
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    logic [2:0]  pend_single [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
    logic [31:0] addr_cont   [6]  = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200};

    initial begin
        // ---------------- reset state ----------------
        idle();
        rst             = 1'b1;
        m0_read         = 1'b1;
        s_readdatavalid = 1'b1;
        next_cycle();
        chk("rst_s_read",   s_read,           0);
        chk("rst_m0_wr",    m0_waitrequest,   1);
        chk("rst_m1_wr",    m1_waitrequest,   1);
        chk("rst_m0_rdv",   m0_readdatavalid, 0);
        chk("rst_pending",  pending,          0);
        chk("rst_rsp_err",  rsp_err,          0);
        idle();
        rst = 1'b0;

        // ---------------- single master, latency 2 ----------------
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            m0_read         = (c < 8);
            m0_address      = 32'(c);
            s_readdatavalid = (c >= 2);
            s_readdata      = 64'hD0 + 64'(c) - 64'd2;
            #1;
            chk($sformatf("single_s_read_c%0d", c), s_read, (c < 8));
            if (c < 8) chk($sformatf("single_addr_c%0d", c), s_address, 64'(c));
            chk($sformatf("single_m0_rdv_c%0d", c), m0_readdatavalid, (c >= 2));
            chk($sformatf("single_m1_rdv_c%0d", c), m1_readdatavalid, 0);
            chk($sformatf("single_pend_c%0d", c), pending, pend_single[c]);
        end
        chk("single_m0_data", m0_readdata, 64'hD7);
        next_cycle();
        idle();
        #1;
        chk("single_pend_end", pending, 0);

        // ---------------- contention from reset ----------------
        do_reset();
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            m0_read         = (c < 6);
            m1_read         = (c < 6);
            m0_address      = 32'h100;
            m1_address      = 32'h200;
            s_readdatavalid = (c >= 1);
            s_readdata      = 64'(c);
            #1;
            if (c < 6) begin
                chk($sformatf("cont_addr_c%0d", c), s_address, addr_cont[c]);
                chk($sformatf("cont_m0_wr_c%0d", c), m0_waitrequest, (c % 2 == 1));
            end
            if (c >= 1) begin
                chk($sformatf("cont_m0_rdv_c%0d", c), m0_readdatavalid, ((c - 1) % 2 == 0));
                chk($sformatf("cont_m1_rdv_c%0d", c), m1_readdatavalid, ((c - 1) % 2 == 1));
            end
        end
        next_cycle();
        idle();
        #1;
        chk("cont_pend_end", pending, 0);

        // ---------------- waitrequest lock ----------------
        next_cycle();
        m1_read = 1'b1; m1_address = 32'h300; s_waitrequest = 1'b1;
        #1;
        chk("lock1_addr",  s_address,      32'h300);
        chk("lock1_sread", s_read,         1);
        chk("lock1_m1_wr", m1_waitrequest, 1);
        next_cycle();
        m0_read = 1'b1; m0_address = 32'h400;
        #1;
        chk("lock2_addr",  s_address,      32'h300);
        chk("lock2_m0_wr", m0_waitrequest, 1);
        next_cycle();
        #1;
        chk("lock3_addr",  s_address,      32'h300);
        next_cycle();
        s_waitrequest = 1'b0;
        #1;
        chk("lock4_addr",  s_address,      32'h300);
        chk("lock4_m1_wr", m1_waitrequest, 0);
        chk("lock4_m0_wr", m0_waitrequest, 1);
        next_cycle();
        m1_read = 1'b0;
        #1;
        chk("lock5_addr",  s_address,      32'h400);
        chk("lock5_m0_wr", m0_waitrequest, 0);
        next_cycle();
        m0_read = 1'b0; s_readdatavalid = 1'b1;
        #1;
        chk("lock6_m1_rdv", m1_readdatavalid, 1);
        chk("lock6_m0_rdv", m0_readdatavalid, 0);
        next_cycle();
        #1;
        chk("lock7_m0_rdv", m0_readdatavalid, 1);
        next_cycle();
        s_readdatavalid = 1'b0;
        #1;
        chk("lock_pend_end", pending, 0);

        // ---------------- full ----------------
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            m0_read = 1'b1; m0_address = 32'h500 + 32'(c);
            #1;
            chk($sformatf("full_accept_c%0d", c), s_read, 1);
        end
        for (int c = 4; c < 6; c++) begin
            next_cycle();
            #1;
            chk($sformatf("full_sread_c%0d", c), s_read, 0);
            chk($sformatf("full_m0_wr_c%0d", c), m0_waitrequest, 1);
            chk($sformatf("full_pend_c%0d", c), pending, 4);
        end
        next_cycle();
        s_readdatavalid = 1'b1;
        #1;
        chk("full_pop_rdv",   m0_readdatavalid, 1);
        chk("full_pop_sread", s_read,           0);
        next_cycle();
        s_readdatavalid = 1'b0;
        #1;
        chk("full_retry_sread", s_read,         1);
        chk("full_retry_m0_wr", m0_waitrequest, 0);
        chk("full_retry_pend",  pending,        3);
        next_cycle();
        m0_read = 1'b0; s_readdatavalid = 1'b1;
        next_cycle();

        // ---------------- simultaneous push/pop at count 2 ----------------
        next_cycle();
        m1_read = 1'b1; m1_address = 32'h600;
        #1;
        chk("pp_pend_before", pending,          2);
        chk("pp_m0_rdv",      m0_readdatavalid, 1);
        chk("pp_m1_rdv",      m1_readdatavalid, 0);
        chk("pp_sread",       s_read,           1);
        next_cycle();
        m1_read = 1'b0;
        #1;
        chk("pp_pend_after", pending,          2);
        chk("pp_next_m0",    m0_readdatavalid, 1);
        next_cycle();
        #1;
        chk("pp_last_m1", m1_readdatavalid, 1);
        chk("pp_last_m0", m0_readdatavalid, 0);
        next_cycle();
        s_readdatavalid = 1'b0;
        #1;
        chk("pp_pend_end", pending, 0);

        // ---------------- orphan response ----------------
        next_cycle();
        s_readdatavalid = 1'b1;
        #1;
        chk("err_m0_rdv", m0_readdatavalid, 0);
        chk("err_m1_rdv", m1_readdatavalid, 0);
        chk("err_pre",    rsp_err,          0);
        next_cycle();
        s_readdatavalid = 1'b0;
        #1;
        chk("err_set",  rsp_err, 1);
        chk("err_pend", pending, 0);

        // ---------------- async reset mid-burst ----------------
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            m0_read = 1'b1; m0_address = 32'h700 + 32'(c);
        end
        next_cycle();
        #1;
        chk("burst_pend",   pending, 3);
        chk("burst_err",    rsp_err, 1);
        rst = 1'b1;
        #1;
        chk("arst_pend",    pending,        0);
        chk("arst_err",     rsp_err,        0);
        chk("arst_sread",   s_read,         0);
        chk("arst_m0_wr",   m0_waitrequest, 1);
        next_cycle();
        rst = 1'b0;
        m0_read = 1'b0;
        s_readdatavalid = 1'b1;
        #1;
        chk("late_rsp_m0_rdv", m0_readdatavalid, 0);
        next_cycle();
        s_readdatavalid = 1'b0;
        #1;
        chk("late_rsp_err", rsp_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_rd_arbiter.md
# avalon_rd_arbiter

Two-master, one-slave Avalon-MM read arbiter. It lets two read masters, such as the matrix/vector fetch master and a second fetch or debug master, share the single pipelined memory slave `mem_wrapper`. Grants are round-robin and held stable across slave waitrequest. Outstanding reads are tracked in an in-order tag FIFO so that each readdatavalid beat is returned only to the master that issued it.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports
- `DATA_WIDTH`, 64, read data width
- `MAX_PENDING`, 4, max accepted-but-unreturned reads (power of 2, ≥2)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_address` / `m1_address`  in  ADDR_WIDTH  master read address
- `m0_read` / `m1_read`  in  1  master read request
- `m0_waitrequest` / `m1_waitrequest`  out  1  command not accepted this cycle
- `m0_readdata` / `m1_readdata`  out  DATA_WIDTH  returned data (both driven from `s_readdata`)
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  data valid for that master
- `s_address`  out  ADDR_WIDTH  address to slave
- `s_read`  out  1  read request to slave
- `s_waitrequest`  in  1  slave busy
- `s_readdata`  in  DATA_WIDTH  slave data
- `s_readdatavalid`  in  1  slave data valid, returns in issue order
- `pending`  out  $clog2(MAX_PENDING)+1  outstanding read count
- `rsp_err`  out  1  sticky: readdatavalid received with no read outstanding

## Operation
- State registers:
  - `last_grant` (1 bit). Reset value 1, so that M0 wins the first tie.
  - `locked` and `lock_id`.
  - Tag FIFO of MAX_PENDING × 1-bit master IDs, with read/write pointers and count.
  - `rsp_err`.
- Arbitration when `locked`=0:
  - Only one master has read=1: that master is granted.
  - Both have read=1: grant `!last_grant`.
  - Neither: no grant, `s_read`=0.
- Arbitration when `locked`=1: grant is `lock_id` regardless of the other request.
- `full` = (count == MAX_PENDING).
- Command path, combinational:
  - `s_read` = granted master's read && !full.
  - `s_address` = granted master's address. When no grant, `s_address` = m0_address.
- Waitrequest:
  - Granted master: `waitrequest` = `s_waitrequest || full`.
  - Non-granted master: `waitrequest`=1.
- Accept = `s_read && !s_waitrequest`. On accept:
  - Push grant ID into the FIFO.
  - `last_grant` ← grant ID.
  - `locked` ← 0.
- Lock: if `s_read && s_waitrequest`, then `locked` ← 1 and `lock_id` ← grant. This keeps the Avalon command stable until accepted.
- Full with `locked`=0: the grant is still computed, but `s_read` is 0 and no lock is taken.
- Response path, combinational:
  - On `s_readdatavalid` with count>0: pop FIFO head H and assert `mH_readdatavalid`. The other master's valid stays 0.
  - `m0_readdata` = `m1_readdata` = `s_readdata` at all times.
- Response with count==0: no valid is routed to either master, pointers are unchanged, and `rsp_err` ← 1.
- Accept and response in the same cycle: push and pop both occur and count is unchanged. `full` is evaluated on the pre-edge count, so a pop does not free a slot for a same-cycle accept.
- Pointers wrap modulo MAX_PENDING.
- `pending` = count.

## Timing
- Command forwarding and response routing have zero cycles of latency (combinational). Arbiter state updates on the clock edge.
- One read can be accepted per cycle. Back-to-back accepts alternate M0/M1 when both request continuously.
- Reset (async assert, clean on edge):
  - count=0, pointers=0, `locked`=0, `last_grant`=1, `rsp_err`=0.
  - While `rst`=1: `s_read`=0, both `mX_waitrequest`=1, both `mX_readdatavalid`=0.
- Reset mid-operation: all tags are discarded. Slave responses arriving after reset are treated as count==0 responses and set `rsp_err`. The system must reset the slave together with this block.
- `rsp_err` clears only on reset.

## Test plan
- Single master: M0 reads 0x0 through 0x7 back-to-back with slave latency 2 and no waitrequest -> 8 accepts in 8 cycles; 8 `m0_readdatavalid` beats with matching data; `m1_readdatavalid` never 1; `pending` peaks at 2.
- Contention: both masters hold read=1 from reset for 6 accepts -> grant order M0,M1,M0,M1,M0,M1; responses routed in that order.
- Waitrequest lock: M1 granted while `s_waitrequest`=1 for 3 cycles and M0 raises read in cycle 2 -> `s_address` stays at M1's address and M1 is accepted in cycle 4; M0 accepted next.
- Full: slave stalls all responses and M0 issues 5 reads with MAX_PENDING=4 -> 4 accepts; `s_read`=0 and `m0_waitrequest`=1 on the 5th until the first `s_readdatavalid`, then accepted the following cycle.
- Simultaneous push/pop at count=2 -> count stays 2; the popped beat goes to the oldest tag.
- Error/reset: `s_readdatavalid` pulse with count=0 -> no master valid and `rsp_err`=1; async `rst` mid-burst with 3 pending -> `pending`=0 immediately and `rsp_err`=0.
